// File: rtl/fwd_pkg.sv
// fwd_pkg: tag record, forward-select encodings and producer match helper for fwd_hazard_unit.
`default_nettype none
package fwd_pkg;

   // Tag rd field is sized for the widest supported register address; narrower AW is zero-extended.
   localparam int FWD_AW_MAX    = 8;
   localparam int FWD_SEL_RF    = 0;
   localparam int FWD_SEL_EXMEM = 1;
   localparam int FWD_SEL_MEMWB = 2;

   typedef struct packed {
      logic                  v;
      logic                  wr;
      logic                  ld;
      logic [FWD_AW_MAX-1:0] rd;
   } fwd_tag_t;

   function automatic logic tag_match(input fwd_tag_t t, input logic [FWD_AW_MAX-1:0] r);
      return t.v && t.wr && (t.rd != '0) && (t.rd == r);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: ID/EX operand information in, forward selects and stall out.
`default_nettype none
interface fwd_hazard_unit_if #(
   parameter int AW     = 5,
   parameter int NSRC   = 2,
   parameter int NSTAGE = 2,
   parameter int SELW   = $clog2(NSTAGE + 1)
);
   logic                 id_valid;
   logic                 id_regWrite;
   logic                 id_isLoad;
   logic [AW-1:0]        id_rd;
   logic [NSRC*AW-1:0]   id_rs;
   logic [NSRC-1:0]      id_src_reg;
   logic [NSRC*AW-1:0]   ex_rs;
   logic [NSRC-1:0]      ex_src_reg;
   logic                 flush;
   logic [NSRC*SELW-1:0] fwd_sel;
   logic                 stall;

   modport master (
      output id_valid, id_regWrite, id_isLoad, id_rd, id_rs, id_src_reg,
      output ex_rs, ex_src_reg, flush,
      input  fwd_sel, stall
   );

   modport slave (
      input  id_valid, id_regWrite, id_isLoad, id_rd, id_rs, id_src_reg,
      input  ex_rs, ex_src_reg, flush,
      output fwd_sel, stall
   );
endinterface
`default_nettype wire

// File: rtl/fwd_src_sel.sv
// fwd_src_sel: picks the youngest producer stage (1..NSTAGE) writing one EX source register.
`default_nettype none
module fwd_src_sel
   import fwd_pkg::*;
#(
   parameter int AW     = 5,
   parameter int NSTAGE = 2,
   parameter int SELW   = $clog2(NSTAGE + 1)
) (
   input  fwd_tag_t        tags [NSTAGE:1],
   input  logic [AW-1:0]   rs,
   input  logic            src_reg,
   output logic [SELW-1:0] sel
);

   // Scan oldest to youngest so the smallest matching stage is the one left standing.
   always_comb begin
      sel = SELW'(FWD_SEL_RF);
      if (src_reg) begin
         for (int k = NSTAGE; k >= 1; k--) begin
            if (tag_match(tags[k], FWD_AW_MAX'(rs))) begin
               sel = SELW'(k);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: destination-tag pipeline, per-source forwarding select and load-use stall.
// Optional stall performance counter enabled by defining FWD_STALL_CNT_EN.
`default_nettype none
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int AW         = 5,
   parameter int NSRC       = 2,
   parameter int NSTAGE     = 2,
   parameter int LOAD_STAGE = 2,
   localparam int SELW      = $clog2(NSTAGE + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   fwd_hazard_unit_if.slave  bus
`ifdef FWD_STALL_CNT_EN
   ,
   output logic [31:0]       perf_stall_cnt
`endif
);

   fwd_tag_t             tags [NSTAGE:0];
   fwd_tag_t             prod [NSTAGE:1];
   fwd_tag_t             tag_in;
   logic                 hazard;
   logic                 stall;
   logic [NSRC*SELW-1:0] sel_all;

   always_comb begin
      tag_in = '0;
      if (bus.id_valid && !stall && !bus.flush) begin
         tag_in.v  = 1'b1;
         tag_in.wr = bus.id_regWrite;
         tag_in.ld = bus.id_isLoad;
         tag_in.rd = FWD_AW_MAX'(bus.id_rd);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= NSTAGE; k++) begin
            tags[k] <= '0;
         end
      end else begin
         tags[0] <= tag_in;
         for (int k = 1; k <= NSTAGE; k++) begin
            tags[k] <= tags[k-1];
         end
      end
   end

   // A load in stages 0..LOAD_STAGE-2 has no data yet; the ID consumer must wait.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         for (int k = 0; k < LOAD_STAGE - 1; k++) begin
            if (bus.id_src_reg[i] && tags[k].ld &&
                tag_match(tags[k], FWD_AW_MAX'(bus.id_rs[i*AW +: AW]))) begin
               hazard = 1'b1;
            end
         end
      end
      stall = bus.id_valid && !bus.flush && hazard;
   end

   always_comb begin
      for (int k = 1; k <= NSTAGE; k++) begin
         prod[k] = tags[k];
      end
   end

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      fwd_src_sel #(
         .AW     (AW),
         .NSTAGE (NSTAGE),
         .SELW   (SELW)
      ) u_src_sel (
         .tags    (prod),
         .rs      (bus.ex_rs[i*AW +: AW]),
         .src_reg (bus.ex_src_reg[i]),
         .sel     (sel_all[i*SELW +: SELW])
      );
   end

   assign bus.fwd_sel = sel_all;
   assign bus.stall   = stall;

`ifdef FWD_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
      end else if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
         perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

`ifndef SYNTHESIS
   logic early_load_use;
   always_comb begin
      early_load_use = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         for (int k = 1; k < LOAD_STAGE; k++) begin
            if (bus.ex_src_reg[i] && tags[k].ld &&
                tag_match(tags[k], FWD_AW_MAX'(bus.ex_rs[i*AW +: AW]))) begin
               early_load_use = 1'b1;
            end
         end
      end
   end

   a_no_early_load_use: assert property (@(posedge clk) disable iff (!rst_n) !early_load_use);
`endif

endmodule
`default_nettype wire
